// File: rtl/fir_out_buffer.sv
// fir_out_buffer: first-word-fall-through output FIFO placed behind the FIR
// filter. Accepts every valid filter sample while space exists (or while the
// head is being consumed in the same cycle), presents the head with a
// valid/ready handshake, and records overflows in a sticky flag plus a
// saturating drop counter.
module fir_out_buffer #(
  parameter int DW    = 9,   // sample width, matches the FIR output
  parameter int DEPTH = 8,   // entries, power of two, at least 2
  parameter int AW    = 3    // pointer width, log2(DEPTH)
) (
  input  logic          CLK,
  input  logic          RST,
  input  logic          VIN,
  input  logic [DW-1:0] DIN,
  input  logic          RDY,
  input  logic          CLR_OVF,
  output logic          VOUT,
  output logic [DW-1:0] DOUT,
  output logic          FULL,
  output logic          EMPTY,
  output logic [AW:0]   COUNT,
  output logic          OVF,
  output logic [7:0]    DROPS
);

  localparam logic [AW:0] DEPTH_CNT = (AW+1)'(DEPTH);
  localparam logic [7:0]  DROPS_MAX = 8'd255;

  // Sample storage; contents are never reset, occupancy decides validity.
  logic [DW-1:0] mem [DEPTH];

  logic [AW-1:0] wr_ptr_reg, wr_ptr_next;
  logic [AW-1:0] rd_ptr_reg, rd_ptr_next;
  logic [AW:0]   count_reg, count_next;
  logic          ovf_reg, ovf_next;
  logic [7:0]    drops_reg, drops_next;

  logic             not_empty;
  logic             is_full;
  logic             pop;
  logic             push;
  logic             overflow;
  logic [DEPTH-1:0] wr_en;

  // Handshake decode. A full FIFO still takes a sample when the head
  // leaves on the same edge, so only a stalled full FIFO drops data.
  assign not_empty = (count_reg != '0);
  assign is_full   = (count_reg == DEPTH_CNT);
  assign pop       = not_empty & RDY;
  assign push      = VIN & (~is_full | pop);
  assign overflow  = VIN & is_full & ~RDY;

  // One write enable per entry, selected by the write pointer.
  generate
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_wr_en
      assign wr_en[gi] = push && (wr_ptr_reg == AW'(gi));
    end
  endgenerate

  // Capture the accepted sample into the addressed entry.
  always_ff @(posedge CLK) begin
    for (int i = 0; i < DEPTH; i++) begin
      if (wr_en[i]) begin
        mem[i] <= DIN;
      end
    end
  end

  // Next-state: pointers wrap naturally at DEPTH, occupancy tracks push-pop,
  // overflow beats clear for the flag while clear beats overflow for the count.
  always_comb begin
    wr_ptr_next = wr_ptr_reg;
    rd_ptr_next = rd_ptr_reg;
    count_next  = count_reg + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop};
    ovf_next    = ovf_reg;
    drops_next  = drops_reg;

    if (push) begin
      wr_ptr_next = wr_ptr_reg + AW'(1);
    end
    if (pop) begin
      rd_ptr_next = rd_ptr_reg + AW'(1);
    end

    if (overflow) begin
      ovf_next = 1'b1;
    end else if (CLR_OVF) begin
      ovf_next = 1'b0;
    end

    if (CLR_OVF) begin
      drops_next = 8'd0;
    end else if (overflow && (drops_reg != DROPS_MAX)) begin
      drops_next = drops_reg + 8'd1;
    end
  end

  // Control state register; reset empties the FIFO at once, no edge needed.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
      ovf_reg    <= 1'b0;
      drops_reg  <= 8'd0;
    end else begin
      wr_ptr_reg <= wr_ptr_next;
      rd_ptr_reg <= rd_ptr_next;
      count_reg  <= count_next;
      ovf_reg    <= ovf_next;
      drops_reg  <= drops_next;
    end
  end

  // Outputs come straight from state; DOUT is forced to zero when empty so
  // stale memory never shows up on the bus.
  assign VOUT  = not_empty;
  assign EMPTY = ~not_empty;
  assign FULL  = is_full;
  assign COUNT = count_reg;
  assign DOUT  = not_empty ? mem[rd_ptr_reg] : '0;
  assign OVF   = ovf_reg;
  assign DROPS = drops_reg;

endmodule
